// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Register-file write-port initiator. Results from the ALU (src0) and the
//   load unit (src1) are accepted over valid/ready handshakes. At most one
//   result is accepted per cycle, using round-robin arbitration when both
//   sources are valid. Accepted results go into a small in-order FIFO. The
//   FIFO retires one entry per cycle into the register file, which always
//   accepts. Pending-write lookups on two read addresses let the issue logic
//   stall on registers that are not yet written.
//
// Optional feature (macro REGFILE_WRITEBACK_BYPASS_EN):
//   Adds the qN_hit/qN_data outputs. qN_data returns the data of the youngest
//   buffered write to qN_addr, so the consumer can forward it instead of
//   stalling.
//
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   s0_valid/ready/addr/data      ALU result handshake
//   s1_valid/ready/addr/data      load result handshake
//   we, addrw, dataw              regfile write port, driven from FIFO head
//   q0_addr, q1_addr              read addresses to check
//   q0_pend, q1_pend              a buffered write targets qN_addr
//   q0_hit/q0_data, q1_hit/q1_data  (bypass build only) forwarding data
module regfile_writeback #(
    parameter int XLEN  = 8,
    parameter int N     = 8,
    parameter int A     = $clog2(N),
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s0_valid,
    output logic            s0_ready,
    input  logic [A-1:0]    s0_addr,
    input  logic [XLEN-1:0] s0_data,
    input  logic            s1_valid,
    output logic            s1_ready,
    input  logic [A-1:0]    s1_addr,
    input  logic [XLEN-1:0] s1_data,
    output logic            we,
    output logic [A-1:0]    addrw,
    output logic [XLEN-1:0] dataw,
    input  logic [A-1:0]    q0_addr,
    input  logic [A-1:0]    q1_addr,
    output logic            q0_pend,
    output logic            q1_pend
`ifdef REGFILE_WRITEBACK_BYPASS_EN
    ,
    output logic            q0_hit,
    output logic [XLEN-1:0] q0_data,
    output logic            q1_hit,
    output logic [XLEN-1:0] q1_data
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic            rr_q;              // 0: src0 wins a tie, 1: src1 wins
    logic [DEPTH-1:0] vld_q;            // per-slot occupancy, used by the lookups
    logic [A-1:0]    addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];

    logic            full, empty;
    logic            gnt0, gnt1;
    logic            acc0, acc1;
    logic            push, pop;
    logic [A-1:0]    in_addr;
    logic [XLEN-1:0] in_data;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Grant goes to the only valid source. On a tie, the round-robin pointer
    // decides.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (s0_valid && s1_valid) begin
            gnt0 = ~rr_q;
            gnt1 = rr_q;
        end else begin
            gnt0 = s0_valid;
            gnt1 = s1_valid;
        end
    end

    // There is no pass-through: a full FIFO refuses input even on a pop cycle.
    assign s0_ready = gnt0 & ~full & ~rst;
    assign s1_ready = gnt1 & ~full & ~rst;
    assign acc0     = s0_valid & s0_ready;
    assign acc1     = s1_valid & s1_ready;

    assign in_addr = acc1 ? s1_addr : s0_addr;
    assign in_data = acc1 ? s1_data : s0_data;

    // A write to register 0 completes its handshake but is dropped here.
    assign push    = (acc0 | acc1) && (in_addr != '0);
    assign pop     = ~empty;              // regfile always accepts
    assign count_d = count_q + CW'(push) - CW'(pop);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            rr_q     <= 1'b0;
            vld_q    <= '0;
            // NOTE: the storage array is reset on purpose. The head slot drives
            // addrw/dataw directly, and those outputs must read 0 in reset.
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (pop) begin
                rd_ptr_q        <= rd_ptr_q + PW'(1);
                vld_q[rd_ptr_q] <= 1'b0;
            end
            // push and pop never hit the same slot: that needs count 0 or DEPTH
            if (push) begin
                wr_ptr_q         <= wr_ptr_q + PW'(1);
                vld_q[wr_ptr_q]  <= 1'b1;
                addr_q[wr_ptr_q] <= in_addr;
                data_q[wr_ptr_q] <= in_data;
            end
            // Only a contested grant that is taken flips the priority.
            if (s0_valid && s1_valid && (acc0 || acc1))
                rr_q <= ~rr_q;
        end
    end

    assign we    = ~empty;
    assign addrw = addr_q[rd_ptr_q];
    assign dataw = data_q[rd_ptr_q];

    // The head entry counts as pending. The regfile captures it only at the
    // coming edge.
    always_comb begin
        q0_pend = 1'b0;
        q1_pend = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (addr_q[i] == q0_addr) && (q0_addr != '0)) q0_pend = 1'b1;
            if (vld_q[i] && (addr_q[i] == q1_addr) && (q1_addr != '0)) q1_pend = 1'b1;
        end
    end

`ifdef REGFILE_WRITEBACK_BYPASS_EN
    logic [PW-1:0] scan_idx;

    assign q0_hit = q0_pend;
    assign q1_hit = q1_pend;

    // Walk from the oldest slot to the youngest. A later match overrides an
    // earlier one, so the youngest matching write wins.
    always_comb begin
        q0_data  = '0;
        q1_data  = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr_q + PW'(k);
            if (vld_q[scan_idx] && (addr_q[scan_idx] == q0_addr) && (q0_addr != '0))
                q0_data = data_q[scan_idx];
            if (vld_q[scan_idx] && (addr_q[scan_idx] == q1_addr) && (q1_addr != '0))
                q1_data = data_q[scan_idx];
        end
    end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback
//   Scoreboard bench for regfile_writeback.
//   The driver presents per-source item queues and holds each item stable
//   until it is accepted.
//   An acceptance model works out which source is granted and pushes accepted
//   non-zero writes into a scoreboard queue. The model uses a priority bit
//   plus the occupancy of the scoreboard queue.
//   The monitor checks we/addrw/dataw and the pending lookups against the
//   scoreboard, then pops the retiring entry.
//   Timing: inputs change 1 ns after posedge. The monitor runs at negedge. The
//   acceptance model runs 1 ns after negedge.
module tb_regfile_writeback;

    localparam int XLEN  = 8;
    localparam int A     = 3;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [A-1:0]    addr;
        logic [XLEN-1:0] data;
    } item_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            s0_valid, s0_ready, s1_valid, s1_ready;
    logic [A-1:0]    s0_addr, s1_addr;
    logic [XLEN-1:0] s0_data, s1_data;
    logic            we;
    logic [A-1:0]    addrw;
    logic [XLEN-1:0] dataw;
    logic [A-1:0]    q0_addr, q1_addr;
    logic            q0_pend, q1_pend;
`ifdef REGFILE_WRITEBACK_BYPASS_EN
    logic            q0_hit, q1_hit;
    logic [XLEN-1:0] q0_data, q1_data;
`endif

    regfile_writeback #(.XLEN(XLEN), .N(8), .A(A), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
        .we(we), .addrw(addrw), .dataw(dataw),
        .q0_addr(q0_addr), .q1_addr(q1_addr), .q0_pend(q0_pend), .q1_pend(q1_pend)
`ifdef REGFILE_WRITEBACK_BYPASS_EN
        , .q0_hit(q0_hit), .q0_data(q0_data), .q1_hit(q1_hit), .q1_data(q1_data)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    item_t src_q0[$];
    item_t src_q1[$];
    item_t sb[$];          // writes accepted and not yet retired, oldest first

    bit pres0 = 0, pres1 = 0;   // driver is presenting the head item
    bit acc0 = 0, acc1 = 0;     // model says that item is accepted this cycle
    bit popped = 0;             // monitor retired an entry this cycle
    bit rr_mdl = 0;             // which source wins the next tie
    int rate = 100;             // percent chance to start presenting an item
    bit qrand = 0;
    logic [A-1:0] qa0 = '0, qa1 = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic exp_pend(input logic [A-1:0] qa);
        exp_pend = 1'b0;
        foreach (sb[i]) if (qa != '0 && sb[i].addr == qa) exp_pend = 1'b1;
    endfunction

    function automatic logic [XLEN-1:0] exp_fwd(input logic [A-1:0] qa);
        exp_fwd = '0;
        foreach (sb[i]) if (qa != '0 && sb[i].addr == qa) exp_fwd = sb[i].data;
    endfunction

    // Driver: holds a presented item until the model reports acceptance.
    always begin
        item_t tmp;
        @(posedge clk);
        #1;
        if (acc0) begin tmp = src_q0.pop_front(); pres0 = 0; end
        if (acc1) begin tmp = src_q1.pop_front(); pres1 = 0; end
        if (!pres0 && src_q0.size() > 0 && $urandom_range(99) < rate) pres0 = 1;
        if (!pres1 && src_q1.size() > 0 && $urandom_range(99) < rate) pres1 = 1;
        s0_valid = pres0;
        s1_valid = pres1;
        if (pres0) {s0_addr, s0_data} = src_q0[0];
        else       {s0_addr, s0_data} = (A + XLEN)'($urandom);
        if (pres1) {s1_addr, s1_data} = src_q1[0];
        else       {s1_addr, s1_data} = (A + XLEN)'($urandom);
        if (qrand) begin
            q0_addr = A'($urandom_range(7));
            q1_addr = A'($urandom_range(7));
        end else begin
            q0_addr = qa0;
            q1_addr = qa1;
        end
    end

    // Monitor: checks the write port and lookups, then retires the head.
    always @(negedge clk) begin
        item_t e;
        popped = 0;
        if (rst) begin
            check("rst_we", we, 0);
            check("rst_s0_ready", s0_ready, 0);
            check("rst_s1_ready", s1_ready, 0);
            check("rst_q0_pend", q0_pend, 0);
            sb.delete();
        end else begin
            check("q0_pend", q0_pend, exp_pend(q0_addr));
            check("q1_pend", q1_pend, exp_pend(q1_addr));
`ifdef REGFILE_WRITEBACK_BYPASS_EN
            check("q0_hit", q0_hit, exp_pend(q0_addr));
            check("q0_data", q0_data, exp_fwd(q0_addr));
            check("q1_data", q1_data, exp_fwd(q1_addr));
`endif
            check("we", we, sb.size() != 0);
            if (we && sb.size() != 0) begin
                e = sb.pop_front();
                check("addrw", addrw, e.addr);
                check("dataw", dataw, e.data);
                popped = 1;
            end
        end
    end

    // Acceptance model: grant rules and FIFO occupancy from the scoreboard.
    always @(negedge clk) begin
        bit full, v0, v1, g1, er0, er1;
        #1;
        acc0 = 0;
        acc1 = 0;
        if (rst) begin
            rr_mdl = 0;
        end else begin
            full = (sb.size() + int'(popped)) == DEPTH;
            v0 = s0_valid;
            v1 = s1_valid;
            g1 = (v0 && v1) ? rr_mdl : v1;
            er0 = v0 && !g1 && !full;
            er1 = v1 && g1 && !full;
            check("s0_ready", s0_ready, er0);
            check("s1_ready", s1_ready, er1);
            if (er0 && s0_addr != '0) sb.push_back({s0_addr, s0_data});
            if (er1 && s1_addr != '0) sb.push_back({s1_addr, s1_data});
            if (v0 && v1 && (er0 || er1)) rr_mdl = ~rr_mdl;
            acc0 = er0;
            acc1 = er1;
        end
    end

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while ((src_q0.size() != 0 || src_q1.size() != 0 || sb.size() != 0) && n < max_cycles) begin
            @(posedge clk);
            n++;
        end
        if (n >= max_cycles) check("drain_timeout", 1, 0);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1;
        s0_valid = 0; s1_valid = 0;
        s0_addr = '0; s1_addr = '0; s0_data = '0; s1_data = '0;
        q0_addr = '0; q1_addr = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single write into an empty FIFO.
        qa0 = 3;
        src_q0.push_back({3'd3, 8'h55});
        wait_drain(50);

        // Both sources contending: expect writes 1,5,2,6.
        src_q0.push_back({3'd1, 8'h10}); src_q0.push_back({3'd2, 8'h20});
        src_q1.push_back({3'd5, 8'h50}); src_q1.push_back({3'd6, 8'h60});
        wait_drain(50);

        // Burst of five from the ALU.
        for (int i = 0; i < 5; i++) src_q0.push_back({A'(i + 1), 8'(8'hA0 + i)});
        wait_drain(50);

        // Register 0 write: the handshake completes, but nothing is written.
        qa0 = 0;
        src_q1.push_back({3'd0, 8'hAA});
        wait_drain(50);

        // Two writes to r4 with a lookup on r4.
        qa0 = 4; qa1 = 4;
        src_q0.push_back({3'd4, 8'h11}); src_q0.push_back({3'd4, 8'h22});
        wait_drain(50);

        // Reset mid-operation discards buffered entries.
        for (int i = 0; i < 4; i++) begin
            src_q0.push_back({A'(i + 1), 8'($urandom)});
            src_q1.push_back({A'(7 - i), 8'($urandom)});
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_drain(100);

        // Random traffic with random lookups.
        rate = 50;
        qrand = 1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(1)) src_q0.push_back(item_t'($urandom));
            else                   src_q1.push_back(item_t'($urandom));
        end
        wait_drain(3000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
